dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported `data_mem` between the processor core's load/store path and a host/loader port used by the bench to preload operands and read back results. It sits between `Ctrl`/`ALU` (core side), the host port, and `data_mem`. It issues at most one memory access per cycle, returns registered read data with a one-cycle ack, and drives a stall flag back toward the program counter.

## Interface
- AW, 8, address width (matches `data_mem` DataAddress)
- DW, 8, data width
- CLK  in  1  clock, posedge
- reset_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  registered read data, valid with core_ack
- core_ack  out  1  one-cycle completion pulse
- core_stall  out  1  core_req & ~core_ack, combinational; PC holds when high
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request, same rules as core
- host_rdata  out  DW  registered read data, valid with host_ack
- host_ack  out  1  one-cycle completion pulse
- mem_addr  out  AW  to data_mem DataAddress
- mem_re  out  1  to data_mem ReadMem
- mem_we  out  1  to data_mem WriteMem
- mem_wdata  out  DW  to data_mem DataIn
- mem_rdata  in  DW  from data_mem DataOut, combinational read
- busy  out  1  an access was issued this cycle

## Operation
- FSM state = owner of previous cycle's access: IDLE, CORE_ACC, HOST_ACC.
- Eligibility: port p is eligible when p_req=1 and state != p_ACC (a port's ack cycle is never an issue cycle for that port; the same req held high after ack is a new request, issued earliest the cycle after ack).
- Grant: one eligible port -> grant it. Both eligible -> grant the port not granted most recently (last_grant register, reset = HOST so core wins first tie).
- Issue (combinational in grant cycle): mem_addr/mem_wdata/mem_we from granted port; mem_re = ~we; no grant -> mem_re=mem_we=0, mem_addr/mem_wdata=0.
- Next state = CORE_ACC / HOST_ACC / IDLE by grant. In p_ACC: p_ack=1; p_rdata holds mem_rdata captured at issue edge (reads only; unchanged on writes).
- Rdata registers hold value until next read completes on that port.
- Requester changing addr/we/wdata while req high and unacked: undefined; bench flags as protocol error.
- Write-then-read same address by either port: read returns the written value (accesses strictly serialized).

## Timing
- Reset (reset_n=0, async): state=IDLE, last_grant=HOST, core_ack=host_ack=0, core_rdata=host_rdata=0, busy=0, mem_re=mem_we=0, mem_addr=mem_wdata=0.
- Latency: request in cycle N with port eligible and granted -> ack in N+1.
- Per-port throughput: 1 access / 2 cycles; aggregate: 1 access/cycle with both ports active (strict alternation).
- Reset asserted mid-access: access in flight is dropped, no ack is produced; a write issued in the reset cycle is not guaranteed.
- First cycle after reset release: core_req and host_req both high -> core granted.

## Configuration
- DMEM_ARB_STATS_EN defined: adds outputs core_cnt, host_cnt, conflict_cnt (16 bits each, saturate at 16'hFFFF, reset 0). core_cnt/host_cnt increment per grant; conflict_cnt increments per cycle both ports were eligible.
- Undefined: ports and counters absent; arbitration identical.

## Test plan
- Host writes 8'h3C to addr 8'h10, then reads it back, core idle -> mem_we at issue cycle, host_ack next cycle, host_rdata=8'h3C on read ack.
- Core and host request together from reset, core reads 8'h10, host reads 8'h11 -> core granted cycle 0, host cycle 1, acks cycles 1 and 2, core_stall high only in cycle 0.
- Both hold req high for 10 cycles -> grants alternate C,H,C,H…, 10 accesses total, neither port issues in its own ack cycle.
- Core write 8'hA5 to 8'h20 while host reads 8'h20 in the following cycle -> host_rdata=8'hA5.
- reset_n pulled low in the ack cycle of a core read -> core_ack and core_rdata drop to 0 immediately; after release, IDLE and a fresh core request acks after 1 cycle.
- With DMEM_ARB_STATS_EN, 6-cycle dual-request run -> core_cnt=3, host_cnt=3, conflict_cnt=1 (first cycle only).

Source files
------------

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing single-ported data_mem between the
//            core load/store path and a host/loader port. Optional counters
//            enabled by defining DMEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   core_cnt,
    output logic [15:0]   host_cnt,
    output logic [15:0]   conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE_ACC = 2'd1,
        ST_HOST_ACC = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last_host;
    logic          r_core_ack;
    logic          r_host_ack;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_host_rdata;

    logic w_core_elig;
    logic w_host_elig;
    logic w_grant_core;
    logic w_grant_host;

    assign w_core_elig = core_req && (r_state != ST_CORE_ACC);
    assign w_host_elig = host_req && (r_state != ST_HOST_ACC);

    // Nothing is issued while reset is held so no access can leak to memory.
    assign w_grant_core = reset_n && w_core_elig && (!w_host_elig || r_last_host);
    assign w_grant_host = reset_n && w_host_elig && !w_grant_core;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (w_grant_core) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
            mem_re    = !core_we;
        end else if (w_grant_host) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
            mem_re    = !host_we;
        end
    end

    assign busy       = w_grant_core || w_grant_host;
    assign core_ack   = r_core_ack;
    assign host_ack   = r_host_ack;
    assign core_rdata = r_core_rdata;
    assign host_rdata = r_host_rdata;
    assign core_stall = core_req && !r_core_ack;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_host  <= 1'b1;
            r_core_ack   <= 1'b0;
            r_host_ack   <= 1'b0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_core_ack <= w_grant_core;
            r_host_ack <= w_grant_host;
            if (w_grant_core) begin
                r_state     <= ST_CORE_ACC;
                r_last_host <= 1'b0;
                if (!core_we) begin
                    r_core_rdata <= mem_rdata;
                end
            end else if (w_grant_host) begin
                r_state     <= ST_HOST_ACC;
                r_last_host <= 1'b1;
                if (!host_we) begin
                    r_host_rdata <= mem_rdata;
                end
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_core_cnt;
    logic [15:0] r_host_cnt;
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_core_cnt     <= 16'd0;
            r_host_cnt     <= 16'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (w_grant_core && (r_core_cnt != 16'hFFFF)) begin
                r_core_cnt <= r_core_cnt + 16'd1;
            end
            if (w_grant_host && (r_host_cnt != 16'hFFFF)) begin
                r_host_cnt <= r_host_cnt + 16'd1;
            end
            if (w_core_elig && w_host_elig && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign core_cnt     = r_core_cnt;
    assign host_cnt     = r_host_cnt;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

`default_nettype wire
